// File: rtl/conv1d_pkg.sv
// ---------------------------------------------------------------------------
// conv1d_pkg
// Shared types and constants for the conv1d tap sequencer.
//   state_e     : sequencer states (IDLE, MAC, BRANCH)
//   DATA_W_DEF  : default sample / weight width
//   WIDTH_DEF   : default accumulator width
//   clog2_min1  : address width helper that never returns 0
// ---------------------------------------------------------------------------
package conv1d_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int WIDTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        BRANCH
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv1d_tap_mult.sv
// ---------------------------------------------------------------------------
// conv1d_tap_mult
// Registered signed multiplier for one tap. The full 2*DATA_W product is
// sign-extended to WIDTH and presented one cycle after en_i, together with
// the accumulator control flags for that product.
//   clk, rst  : clock, synchronous active-high reset
//   en_i      : a tap product is requested this cycle
//   first_i   : this is tap 0 of the pass (accumulator restarts from zero)
//   a_i, b_i  : signed sample and weight
//   prod_o    : sign-extended product (holds its value while en_i is low)
//   sel_o     : registered first_i, qualified by en_i
//   ld_tmp_o  : registered en_i
// ---------------------------------------------------------------------------
module conv1d_tap_mult
    import conv1d_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     first_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic        [WIDTH-1:0]  prod_o,
    output logic                     sel_o,
    output logic                     ld_tmp_o
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_full;
    logic        [WIDTH-1:0] prod_q;
    logic                    sel_q;
    logic                    ld_tmp_q;

    // Operands widened first so the multiply is evaluated at full product width.
    assign prod_full = PW'(a_i) * PW'(b_i);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for every register so all flops sample
        // the same pre-edge values regardless of statement order.
        if (rst) begin
            prod_q   <= '0;
            sel_q    <= 1'b0;
            ld_tmp_q <= 1'b0;
        end else begin
            ld_tmp_q <= en_i;
            sel_q    <= en_i & first_i;
            if (en_i) begin
                // Size cast of a signed value sign-extends to WIDTH.
                prod_q <= WIDTH'(prod_full);
            end
        end
    end

    assign prod_o   = prod_q;
    assign sel_o    = sel_q;
    assign ld_tmp_o = ld_tmp_q;

endmodule

// File: rtl/conv1d_tap_sequencer.sv
// ---------------------------------------------------------------------------
// conv1d_tap_sequencer
// Front end of the conv1d accumulator. Holds a sliding window of samples
// (win[0] oldest) and KERNEL weights; for every accepted sample once the
// window is full it walks taps 0..KERNEL-1 issuing win[k]*w[k] products,
// then pulses acc_ld_branch and, one cycle later, result_valid.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready/in_data: sample handshake (accepted only in IDLE)
//   flush                    : empty the window (IDLE only, beats in_valid)
//   w_we/w_addr/w_data       : weight write, honoured only while idle
//   busy                     : high outside IDLE
//   acc_din                  : sign-extended product to the accumulator
//   acc_sel                  : accumulator adds to zero (tap 0)
//   acc_ld_tmp               : accumulator tmp-register load
//   acc_ld_branch            : accumulator output-register load
//   result_valid             : accumulator output holds a new result
// ---------------------------------------------------------------------------
module conv1d_tap_sequencer
    import conv1d_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int KERNEL = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [DATA_W-1:0]      in_data,
    input  logic                          flush,
    input  logic                          w_we,
    input  logic [clog2_min1(KERNEL)-1:0] w_addr,
    input  logic signed [DATA_W-1:0]      w_data,
    output logic                          busy,
    output logic        [WIDTH-1:0]       acc_din,
    output logic                          acc_sel,
    output logic                          acc_ld_tmp,
    output logic                          acc_ld_branch,
    output logic                          result_valid
);

    localparam int            AW        = clog2_min1(KERNEL);
    localparam int            FW        = $clog2(KERNEL + 1);
    localparam logic [AW-1:0] K_LAST    = AW'(KERNEL - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(KERNEL);

    state_e                   state_q;
    logic [AW-1:0]            k_q;
    logic [FW-1:0]            fill_q;
    logic [FW-1:0]            fill_d;
    logic signed [DATA_W-1:0] win_q [KERNEL];
    logic signed [DATA_W-1:0] w_q   [KERNEL];
    logic                     ld_branch_q;
    logic                     result_valid_q;
    logic                     accept;
    logic                     w_addr_ok;

    assign busy      = (state_q != IDLE);
    assign in_ready  = !busy && !flush;
    assign accept    = in_valid && in_ready;
    assign w_addr_ok = (int'(w_addr) < KERNEL);

    // Post-accept fill count; decides whether this accept starts a pass.
    always_comb begin
        // NOTE: default assignment first so no path leaves fill_d unassigned
        // and no latch is inferred.
        fill_d = fill_q;
        if (!busy && flush) begin
            fill_d = '0;
        end else if (accept && (fill_q != FILL_FULL)) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            k_q            <= '0;
            fill_q         <= '0;
            ld_branch_q    <= 1'b0;
            result_valid_q <= 1'b0;
            // NOTE: window and weight storage are reset explicitly because a
            // reset must leave a known all-zero window and kernel behind.
            for (int i = 0; i < KERNEL; i++) begin
                win_q[i] <= '0;
                w_q[i]   <= '0;
            end
        end else begin
            fill_q         <= fill_d;
            ld_branch_q    <= (state_q == BRANCH);
            result_valid_q <= ld_branch_q;

            // Writes in the accepting cycle land before tap 0 is read.
            if (w_we && !busy && w_addr_ok) begin
                w_q[w_addr] <= w_data;
            end

            if (accept) begin
                for (int i = 0; i < KERNEL - 1; i++) begin
                    win_q[i] <= win_q[i+1];
                end
                win_q[KERNEL-1] <= in_data;
            end

            unique case (state_q)
                IDLE: begin
                    if (accept && (fill_d == FILL_FULL)) begin
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    if (k_q == K_LAST) begin
                        k_q     <= '0;
                        state_q <= BRANCH;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                // Last product is on acc_din now; ld_branch follows next cycle.
                BRANCH:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    conv1d_tap_mult #(
        .DATA_W (DATA_W),
        .WIDTH  (WIDTH)
    ) u_mult (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q == MAC),
        .first_i  (k_q == '0),
        .a_i      (win_q[k_q]),
        .b_i      (w_q[k_q]),
        .prod_o   (acc_din),
        .sel_o    (acc_sel),
        .ld_tmp_o (acc_ld_tmp)
    );

    assign acc_ld_branch = ld_branch_q;
    assign result_valid  = result_valid_q;

endmodule
